// File: rtl/seg7_mux_driver.sv
// Dual-digit common-anode seven-segment multiplexer: hex decode, per-digit
// dwell, and blanking dead-time between digit switches to suppress ghosting.
module seg7_mux_driver #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);

  localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  // The idle BLANK1 (after reset or while disabled) runs a full BLANK_CYCLES
  // once released, so it is loaded one higher than a normal blank entry.
  localparam logic [CNT_W-1:0] IDLE_LOAD  = CNT_W'(BLANK_CYCLES);
  localparam logic [6:0]       SEG_DARK   = 7'b1111111;

  typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;

  // Active-low segment pattern, bit order g..a.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] p;
    p = SEG_DARK;
    case (v)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0010000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      4'hF: p = 7'b0001110;
      default: p = SEG_DARK;
    endcase
    return p;
  endfunction

  // Successor of the current state once its dwell has expired.
  always_comb begin
    next_state = BLANK1;
    case (state)
      SHOW0:   next_state = (BLANK_CYCLES == 0) ? SHOW1 : BLANK0;
      BLANK0:  next_state = SHOW1;
      SHOW1:   next_state = (BLANK_CYCLES == 0) ? SHOW0 : BLANK1;
      BLANK1:  next_state = SHOW0;
      default: next_state = BLANK1;
    endcase
  end

  // State, dwell counter and all pin drivers update on the same edge.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      state <= BLANK1;
      cnt   <= IDLE_LOAD;
      an    <= 2'b11;
      seg   <= SEG_DARK;
      frame <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        state <= next_state;
        case (next_state)
          SHOW0: begin
            cnt   <= DWELL_LOAD;
            an    <= 2'b10;
            seg   <= decode(s0);
            frame <= 1'b1;
          end
          SHOW1: begin
            cnt <= DWELL_LOAD;
            an  <= 2'b01;
            seg <= decode(s1);
          end
          default: begin
            cnt <= BLANK_LOAD;
            an  <= 2'b11;
            seg <= SEG_DARK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver: default build plus a DWELL=1/BLANK=0
// build sharing the same inputs.
module tb_seg7_mux_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] s0;
  logic [3:0] s1;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       frame_a, frame_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0] an;
    logic [6:0] seg;
    logic       frame;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  localparam logic [6:0] DARK = 7'b1111111;
  logic [6:0] font [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_mux_driver #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .s0(s0), .s1(s1),
    .seg(seg_a), .an(an_a), .frame(frame_a)
  );

  seg7_mux_driver #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .s0(s0), .s1(s1),
    .seg(seg_b), .an(an_b), .frame(frame_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per cycle per build and compares.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checks++;
      if (an_a !== e.an || seg_a !== e.seg || frame_a !== e.frame) begin
        errors++;
        $display("FAIL dflt cyc %0d: got an=%b seg=%b frame=%b want an=%b seg=%b frame=%b",
                 cyc, an_a, seg_a, frame_a, e.an, e.seg, e.frame);
      end
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      checks++;
      if (an_b !== e.an || seg_b !== e.seg || frame_b !== e.frame) begin
        errors++;
        $display("FAIL fast cyc %0d: got an=%b seg=%b frame=%b want an=%b seg=%b frame=%b",
                 cyc, an_b, seg_b, frame_b, e.an, e.seg, e.frame);
      end
    end
    if (an_a === 2'b00 || an_b === 2'b00) begin
      errors++;
      $display("FAIL both_anodes cyc %0d: an_a=%b an_b=%b want never 00", cyc, an_a, an_b);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic void push1(logic [1:0] a, logic [6:0] s, logic f);
    q1.push_back('{an: a, seg: s, frame: f});
  endfunction

  function automatic void push2(logic [1:0] a, logic [6:0] s, logic f);
    q2.push_back('{an: a, seg: s, frame: f});
  endfunction

  // n cycles of one display phase on the default build; frame only on the first.
  task automatic phase(input logic [1:0] a, input logic [6:0] s, input logic first, input int n);
    for (int k = 0; k < n; k++) begin
      adv();
      push1(a, s, first && (k == 0));
    end
  endtask

  task automatic run_frame(input logic [6:0] e0, input logic [6:0] e1);
    phase(2'b10, e0, 1'b1, 4);
    phase(2'b11, DARK, 1'b0, 1);
    phase(2'b01, e1, 1'b0, 4);
    phase(2'b11, DARK, 1'b0, 1);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1; en = 1'b1; s0 = 4'h1; s1 = 4'h8;
    adv();
    push1(2'b11, DARK, 1'b0);
    push2(2'b11, DARK, 1'b0);
    reset = 1'b0;
    phase(2'b11, DARK, 1'b0, 1);
    run_frame(font[1], font[8]);

    // Sweep digit 0 through the full font.
    for (int i = 0; i < 16; i++) begin
      s0 = 4'(i);
      run_frame(font[i], font[8]);
    end

    // Digit 1 changes mid-dwell: held until the next SHOW1 entry.
    s0 = 4'h2; s1 = 4'h7;
    phase(2'b10, font[2], 1'b1, 4);
    phase(2'b11, DARK, 1'b0, 1);
    phase(2'b01, font[7], 1'b0, 1);
    s1 = 4'hF;
    phase(2'b01, font[7], 1'b0, 3);
    phase(2'b11, DARK, 1'b0, 1);
    run_frame(font[2], font[15]);

    // Enable drop in the 3rd cycle of SHOW0 for 5 cycles.
    s0 = 4'h6; s1 = 4'h9;
    phase(2'b10, font[6], 1'b1, 3);
    en = 1'b0;
    phase(2'b11, DARK, 1'b0, 5);
    en = 1'b1;
    phase(2'b11, DARK, 1'b0, 1);
    run_frame(font[6], font[9]);

    // One-cycle reset in the middle of SHOW1.
    phase(2'b10, font[6], 1'b1, 4);
    phase(2'b11, DARK, 1'b0, 1);
    phase(2'b01, font[9], 1'b0, 2);
    reset = 1'b1; s0 = 4'h5;
    phase(2'b11, DARK, 1'b0, 1);
    reset = 1'b0;
    phase(2'b11, DARK, 1'b0, 1);
    run_frame(font[5], font[9]);

    // Fast build: alternate digits every cycle straight out of reset.
    s0 = 4'h3; s1 = 4'hA;
    reset = 1'b1;
    adv();
    push1(2'b11, DARK, 1'b0);
    push2(2'b11, DARK, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      adv();
      if (k % 2 == 0) push2(2'b10, font[3], 1'b1);
      else            push2(2'b01, font[10], 1'b0);
    end

    adv();
    adv();
    checks++;
    if (q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q1.size() + q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
